// File: rtl/sfu_psum_feeder.sv
// Streams stored per-pixel partial sums from PMEM into the SFU accumulator and
// writes each pixel's ReLU result from the SFU into OMEM.
module sfu_psum_feeder #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int num_pix = 16,
    parameter int num_kij = 9,
    parameter int addr_bw = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       psum_base,
    input  logic [addr_bw-1:0]       out_base,
    output logic                     busy,
    output logic                     done,
    output logic                     pmem_cen,
    output logic                     pmem_wen,
    output logic [addr_bw-1:0]       pmem_addr,
    input  logic [psum_bw*col-1:0]   pmem_rdata,
    output logic [psum_bw*col-1:0]   sfu_psum,
    output logic                     sfu_acc,
    output logic                     sfu_bypass,
    input  logic [psum_bw*col-1:0]   sfp_in,
    output logic                     omem_cen,
    output logic                     omem_wen,
    output logic [addr_bw-1:0]       omem_addr,
    output logic [psum_bw*col-1:0]   omem_wdata
);

    localparam int KW = (num_kij > 1) ? $clog2(num_kij) : 1;
    localparam int PW = (num_pix > 1) ? $clog2(num_pix) : 1;
    localparam logic [KW-1:0]      K_LAST   = KW'(num_kij - 1);
    localparam logic [PW-1:0]      P_LAST   = PW'(num_pix - 1);
    localparam logic [addr_bw-1:0] ROW_STEP = addr_bw'(num_pix);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_GAP,
        S_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [PW-1:0]        p_q, p_d;
    logic [addr_bw-1:0]   row_q, row_d;
    logic [addr_bw-1:0]   psum_base_q, psum_base_d;
    logic [addr_bw-1:0]   out_base_q, out_base_d;
    logic                 acc_q, acc_d;
    logic                 gap1_q, gap1_d;
    logic                 gap2_q, gap2_d;
    logic [addr_bw-1:0]   oaddr1_q, oaddr1_d;
    logic [addr_bw-1:0]   oaddr2_q, oaddr2_d;
    logic                 rd_issue;
    logic [addr_bw-1:0]   rd_addr;

    // row_q tracks k*num_pix incrementally, so no multiplier is needed.
    assign rd_addr = psum_base_q + row_q + addr_bw'(p_q);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        p_d         = p_q;
        row_d       = row_q;
        psum_base_d = psum_base_q;
        out_base_d  = out_base_q;
        rd_issue    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    psum_base_d = psum_base;
                    out_base_d  = out_base;
                    k_d         = '0;
                    p_d         = '0;
                    row_d       = '0;
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                rd_issue = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = S_GAP;
                end else begin
                    k_d   = k_q + 1'b1;
                    row_d = row_q + ROW_STEP;
                end
            end
            S_GAP: begin
                k_d   = '0;
                row_d = '0;
                if (p_q == P_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    p_d     = p_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if (gap2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write-side pipeline: the GAP marker and the pixel's OMEM address travel
    // two cycles so they line up with the SFU result that follows the flush.
    always_comb begin
        acc_d    = rd_issue;
        gap1_d   = (state_q == S_GAP);
        gap2_d   = gap1_q;
        oaddr1_d = (state_q == S_GAP) ? (out_base_q + addr_bw'(p_q)) : oaddr1_q;
        oaddr2_d = gap1_q ? oaddr1_q : oaddr2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            p_q      <= '0;
            row_q    <= '0;
            acc_q    <= 1'b0;
            gap1_q   <= 1'b0;
            gap2_q   <= 1'b0;
            oaddr2_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            p_q      <= p_d;
            row_q    <= row_d;
            acc_q    <= acc_d;
            gap1_q   <= gap1_d;
            gap2_q   <= gap2_d;
            oaddr2_q <= oaddr2_d;
        end
    end

    always_ff @(posedge clk) begin
        psum_base_q <= psum_base_d;
        out_base_q  <= out_base_d;
        oaddr1_q    <= oaddr1_d;
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DRAIN) && gap2_q;
    assign pmem_cen   = ~rd_issue;
    assign pmem_wen   = 1'b1;
    assign pmem_addr  = rd_issue ? rd_addr : '0;
    assign sfu_psum   = pmem_rdata;
    assign sfu_acc    = acc_q;
    assign sfu_bypass = 1'b0;
    assign omem_cen   = ~gap2_q;
    assign omem_wen   = ~gap2_q;
    assign omem_addr  = oaddr2_q;
    assign omem_wdata = sfp_in;

endmodule

// File: tb/tb_sfu_psum_feeder.sv
// Bench for sfu_psum_feeder: PMEM and SFU behavioural models around the DUT,
// OMEM results compared against per-pixel ReLU sums computed from PMEM contents.
module tb_sfu_psum_feeder;

    localparam int PBW   = 16;
    localparam int COL   = 8;
    localparam int NP    = 2;
    localparam int NK    = 3;
    localparam int AW    = 11;
    localparam int W     = PBW * COL;
    localparam int DEPTH = 1 << AW;
    localparam int G     = NP * (NK + 1);

    logic          clk = 1'b0;
    logic          reset, start;
    logic [AW-1:0] psum_base, out_base;
    logic          busy, done, pmem_cen, pmem_wen, sfu_acc, sfu_bypass, omem_cen, omem_wen;
    logic [AW-1:0] pmem_addr, omem_addr;
    logic [W-1:0]  pmem_rdata, sfu_psum, sfp_in, omem_wdata;

    sfu_psum_feeder #(
        .psum_bw(PBW), .col(COL), .num_pix(NP), .num_kij(NK), .addr_bw(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .psum_base(psum_base), .out_base(out_base),
        .busy(busy), .done(done),
        .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
        .pmem_rdata(pmem_rdata), .sfu_psum(sfu_psum), .sfu_acc(sfu_acc),
        .sfu_bypass(sfu_bypass), .sfp_in(sfp_in),
        .omem_cen(omem_cen), .omem_wen(omem_wen), .omem_addr(omem_addr),
        .omem_wdata(omem_wdata)
    );

    always #5 clk = ~clk;

    logic [W-1:0] pmem [DEPTH];
    always @(posedge clk) if (pmem_cen === 1'b0) pmem_rdata <= pmem[pmem_addr];

    // SFU model: accumulate on acc high; on acc low publish ReLU(sum) and clear.
    int sfu_sum [COL];
    always @(posedge clk) begin
        for (int l = 0; l < COL; l++) begin
            if (sfu_acc === 1'b1) begin
                sfu_sum[l] <= sfu_sum[l] + int'($signed(sfu_psum[l*PBW +: PBW]));
            end else begin
                sfp_in[l*PBW +: PBW] <= (sfu_sum[l] > 0) ? sfu_sum[l][PBW-1:0] : '0;
                sfu_sum[l] <= 0;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    int            done_cyc;
    bit            busy_ok, side_bad;
    bit            acc_tr [$];
    logic [AW-1:0] rd_log [$];
    logic [AW-1:0] wr_addr [$];
    logic [W-1:0]  wr_data [$];
    int            wr_cyc [$];

    function automatic logic [AW-1:0] paddr(input logic [AW-1:0] pb, input int k, input int p);
        return AW'(int'(pb) + k * NP + p);
    endfunction

    function automatic logic [W-1:0] exp_word(input logic [AW-1:0] pb, input int p);
        logic [W-1:0] r;
        int s;
        r = '0;
        for (int l = 0; l < COL; l++) begin
            s = 0;
            for (int k = 0; k < NK; k++) s += int'($signed(pmem[paddr(pb, k, p)][l*PBW +: PBW]));
            r[l*PBW +: PBW] = (s > 0) ? PBW'(s) : '0;
        end
        return r;
    endfunction

    function automatic bit exp_acc(input int c);
        return (c >= 2) && (c <= G + 1) && (((c - 2) % (NK + 1)) < NK);
    endfunction

    // Random lanes; lane 3 sums to exactly 0, lane 7 sums to 0x7FFF.
    task automatic fill_rand(input logic [AW-1:0] pb);
        int v, s;
        for (int p = 0; p < NP; p++) begin
            for (int l = 0; l < COL; l++) begin
                s = 0;
                for (int k = 0; k < NK; k++) begin
                    if (l == 3) v = (k == NK - 1) ? -s : int'($urandom_range(6000)) - 3000;
                    else if (l == 7) v = (k == 0) ? 32'h7FF0 : k + 6;
                    else v = int'($urandom_range(6000)) - 3000;
                    s += v;
                    pmem[paddr(pb, k, p)][l*PBW +: PBW] = PBW'(v);
                end
            end
        end
    endtask

    task automatic run_pass(input logic [AW-1:0] pb, input logic [AW-1:0] ob, input int pulse_cyc);
        done_cyc = -1; busy_ok = 1; side_bad = 0;
        acc_tr.delete(); rd_log.delete(); wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        @(negedge clk);
        if (busy !== 1'b0) busy_ok = 0;
        psum_base = pb; out_base = ob; start = 1'b1;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == pulse_cyc) begin
                start = 1'b1; psum_base = AW'($urandom); out_base = AW'($urandom);
            end
            if (c == pulse_cyc + 1) start = 1'b0;
            if (busy !== 1'b1) busy_ok = 0;
            acc_tr.push_back(sfu_acc === 1'b1);
            if (pmem_wen !== 1'b1 || sfu_bypass !== 1'b0) side_bad = 1;
            if (pmem_cen === 1'b0) rd_log.push_back(pmem_addr);
            if (omem_cen === 1'b0 && omem_wen === 1'b0) begin
                wr_addr.push_back(omem_addr); wr_data.push_back(omem_wdata); wr_cyc.push_back(c);
            end
            if (done === 1'b1) done_cyc = c;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; psum_base = '0; out_base = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, pmem_cen, pmem_wen, sfu_acc, sfu_bypass, omem_cen, omem_wen} !== 8'b0011_0011)
            $display("FAIL reset_ctrl: got %b expected 00110011",
                     {busy, done, pmem_cen, pmem_wen, sfu_acc, sfu_bypass, omem_cen, omem_wen});
        else n_pass++;
        n_checks++;
        if (pmem_addr !== '0) $display("FAIL reset_pmem_addr: got %0d expected 0", pmem_addr); else n_pass++;
        n_checks++;
        if (omem_addr !== '0) $display("FAIL reset_omem_addr: got %0d expected 0", omem_addr); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_directed;
        int v0 [NK] = '{5, 7, -2};
        int v1 [NK] = '{-10, 3, 1};
        for (int k = 0; k < NK; k++) begin
            pmem[paddr(0, k, 0)] = '0; pmem[paddr(0, k, 0)][PBW-1:0] = PBW'(v0[k]);
            pmem[paddr(0, k, 1)] = '0; pmem[paddr(0, k, 1)][PBW-1:0] = PBW'(v1[k]);
        end
        run_pass('0, '0, 0);
        n_checks++;
        if (done_cyc != 10) $display("FAIL dir_done_cycle: got %0d expected 10", done_cyc); else n_pass++;
        n_checks++;
        if (!busy_ok) $display("FAIL dir_busy_window: busy not high exactly over cycles 1..10"); else n_pass++;
        n_checks++;
        if (wr_data.size() != 2) $display("FAIL dir_write_count: got %0d expected 2", wr_data.size());
        else begin
            n_pass++;
            n_checks++;
            if (wr_addr[0] !== 0 || wr_data[0][PBW-1:0] !== 16'd10 || wr_cyc[0] != 6)
                $display("FAIL dir_pix0: got addr %0d lane0 %0d cyc %0d expected addr 0 lane0 10 cyc 6",
                         wr_addr[0], wr_data[0][PBW-1:0], wr_cyc[0]);
            else n_pass++;
            n_checks++;
            if (wr_addr[1] !== 1 || wr_data[1][PBW-1:0] !== 16'd0 || wr_cyc[1] != 10)
                $display("FAIL dir_pix1: got addr %0d lane0 %0d cyc %0d expected addr 1 lane0 0 cyc 10",
                         wr_addr[1], wr_data[1][PBW-1:0], wr_cyc[1]);
            else n_pass++;
        end
    endtask

    task automatic test_lanes;
        logic [AW-1:0] pb, ob;
        pb = AW'($urandom_range(500)); ob = AW'($urandom_range(500));
        fill_rand(pb);
        run_pass(pb, ob, 0);
        n_checks++;
        if (wr_data.size() != NP) $display("FAIL lanes_write_count: got %0d expected %0d", wr_data.size(), NP);
        else n_pass++;
        for (int p = 0; p < NP && p < wr_data.size(); p++) begin
            n_checks++;
            if (wr_addr[p] !== AW'(int'(ob) + p) || wr_data[p] !== exp_word(pb, p))
                $display("FAIL lanes_pix%0d: got addr %0d data %h expected addr %0d data %h",
                         p, wr_addr[p], wr_data[p], AW'(int'(ob) + p), exp_word(pb, p));
            else n_pass++;
        end
    endtask

    task automatic test_acc_probe;
        int bad;
        fill_rand(AW'(100));
        run_pass(AW'(100), AW'(40), 0);
        bad = 0;
        for (int c = 1; c <= acc_tr.size(); c++) if (acc_tr[c-1] != exp_acc(c)) bad++;
        n_checks++;
        if (acc_tr.size() != G + 2 || bad != 0)
            $display("FAIL acc_pattern: got %0d cycles with %0d wrong acc values expected %0d cycles 0 wrong",
                     acc_tr.size(), bad, G + 2);
        else n_pass++;
        n_checks++;
        if (side_bad) $display("FAIL wen_bypass: pmem_wen/sfu_bypass left 1/0 during pass"); else n_pass++;
    endtask

    task automatic test_wrap;
        logic [AW-1:0] pb, ob;
        int bad;
        pb = AW'(DEPTH - 2); ob = AW'(DEPTH - 1);
        fill_rand(pb);
        run_pass(pb, ob, 0);
        bad = (rd_log.size() != NP * NK) ? 1 : 0;
        for (int p = 0; p < NP && bad == 0; p++)
            for (int k = 0; k < NK; k++)
                if (rd_log[p*NK + k] !== paddr(pb, k, p)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL wrap_read_addrs: got %0d reads, %0d wrong, expected %0d wrapped reads",
                               rd_log.size(), bad, NP * NK);
        else n_pass++;
        for (int p = 0; p < NP && p < wr_data.size(); p++) begin
            n_checks++;
            if (wr_addr[p] !== AW'(int'(ob) + p) || wr_data[p] !== exp_word(pb, p))
                $display("FAIL wrap_pix%0d: got addr %0d data %h expected addr %0d data %h",
                         p, wr_addr[p], wr_data[p], AW'(int'(ob) + p), exp_word(pb, p));
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored;
        logic [AW-1:0] pb, ob;
        pb = AW'(300); ob = AW'(77);
        fill_rand(pb);
        for (int rep = 0; rep < 2; rep++) begin
            run_pass(pb, ob, (rep == 0) ? 3 : G + 1);
            n_checks++;
            if (done_cyc != G + 2 || wr_data.size() != NP)
                $display("FAIL ign%0d_timing: got done %0d writes %0d expected done %0d writes %0d",
                         rep, done_cyc, wr_data.size(), G + 2, NP);
            else n_pass++;
            for (int p = 0; p < NP && p < wr_data.size(); p++) begin
                n_checks++;
                if (wr_addr[p] !== AW'(int'(ob) + p) || wr_data[p] !== exp_word(pb, p))
                    $display("FAIL ign%0d_pix%0d: got addr %0d data %h expected addr %0d data %h",
                             rep, p, wr_addr[p], wr_data[p], AW'(int'(ob) + p), exp_word(pb, p));
                else n_pass++;
            end
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL ign_idle_after: got busy %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [AW-1:0] pb, ob;
        int acc_cnt;
        pb = AW'(600); ob = AW'(900);
        fill_rand(pb);
        acc_cnt = 0;
        @(negedge clk);
        psum_base = pb; out_base = ob; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 7) begin
                n_checks++;
                if ({busy, done, pmem_cen, pmem_wen, sfu_acc, sfu_bypass, omem_cen, omem_wen} !== 8'b0011_0011)
                    $display("FAIL midrst_ctrl: got %b expected 00110011",
                             {busy, done, pmem_cen, pmem_wen, sfu_acc, sfu_bypass, omem_cen, omem_wen});
                else n_pass++;
                n_checks++;
                if (pmem_addr !== '0 || omem_addr !== '0)
                    $display("FAIL midrst_addrs: got pmem %0d omem %0d expected 0 0", pmem_addr, omem_addr);
                else n_pass++;
                reset = 1'b0;
            end
            if (c >= 7 && (pmem_cen !== 1'b1 || omem_cen !== 1'b1 || busy !== 1'b0)) acc_cnt++;
            if (c == 6) reset = 1'b1;
        end
        n_checks++;
        if (acc_cnt != 0) $display("FAIL midrst_no_access: got %0d active cycles expected 0", acc_cnt); else n_pass++;
        fill_rand(pb);
        run_pass(pb, ob, 0);
        n_checks++;
        if (done_cyc != G + 2 || wr_data.size() != NP)
            $display("FAIL midrst_rerun_timing: got done %0d writes %0d expected done %0d writes %0d",
                     done_cyc, wr_data.size(), G + 2, NP);
        else n_pass++;
        for (int p = 0; p < NP && p < wr_data.size(); p++) begin
            n_checks++;
            if (wr_addr[p] !== AW'(int'(ob) + p) || wr_data[p] !== exp_word(pb, p))
                $display("FAIL midrst_pix%0d: got addr %0d data %h expected addr %0d data %h",
                         p, wr_addr[p], wr_data[p], AW'(int'(ob) + p), exp_word(pb, p));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] pb, ob;
        logic [W-1:0]  first [NP];
        int            first_done;
        pb = AW'(1200); ob = AW'(1500);
        fill_rand(pb);
        run_pass(pb, ob, 0);
        first_done = done_cyc;
        for (int p = 0; p < NP; p++) first[p] = (p < wr_data.size()) ? wr_data[p] : 'x;
        run_pass(pb, ob, 0);
        n_checks++;
        if (first_done != G + 2 || done_cyc != G + 2 || !busy_ok)
            $display("FAIL b2b_timing: got done %0d then %0d busy_ok %0d expected %0d twice busy_ok 1",
                     first_done, done_cyc, busy_ok, G + 2);
        else n_pass++;
        for (int p = 0; p < NP && p < wr_data.size(); p++) begin
            n_checks++;
            if (first[p] !== exp_word(pb, p) || wr_data[p] !== exp_word(pb, p) || wr_addr[p] !== AW'(int'(ob) + p))
                $display("FAIL b2b_pix%0d: got %h then %h at addr %0d expected %h at addr %0d",
                         p, first[p], wr_data[p], wr_addr[p], exp_word(pb, p), AW'(int'(ob) + p));
            else n_pass++;
        end
    endtask

    initial begin
        for (int l = 0; l < COL; l++) sfu_sum[l] = 0;
        test_reset();
        test_directed();
        test_lanes();
        test_acc_probe();
        test_wrap();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sfu_psum_feeder.md
Name: sfu_psum_feeder

Overview:
- Sequencer that reads stored partial sums back out of PMEM and drives the SFU accumulation port (psum_in, acc, bypass).
- For each output pixel, streams all num_kij kernel-position psums into the SFU with acc high, then lets one acc-low cycle trigger the SFU ReLU/clear.
- Captures the resulting sfp_out and writes it to the output memory (OMEM).
- Sits between PMEM and OMEM, on the read side of the path that stores OFIFO psums into PMEM through SFU bypass.

Parameters:
- psum_bw, 16, bits per psum lane
- col, 8, lanes (output channels) per PMEM/OMEM word
- num_pix, 16, output pixels per layer pass
- num_kij, 9, kernel positions accumulated per pixel
- addr_bw, 11, PMEM/OMEM address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle launch pulse; sampled only in IDLE
- psum_base  in  addr_bw  PMEM base address; latched on accepted start
- out_base  in  addr_bw  OMEM base address; latched on accepted start
- busy  out  1  high from first READ cycle through the done cycle
- done  out  1  one-cycle pulse in the cycle of the final OMEM write
- pmem_cen  out  1  PMEM chip enable, active low
- pmem_wen  out  1  PMEM write enable, active low; held 1 (read only)
- pmem_addr  out  addr_bw  PMEM read address
- pmem_rdata  in  psum_bw*col  PMEM read data, valid the cycle after the address
- sfu_psum  out  psum_bw*col  combinational pass-through of pmem_rdata to SFU psum_in
- sfu_acc  out  1  SFU accumulate enable
- sfu_bypass  out  1  SFU bypass; held 0
- sfp_in  in  psum_bw*col  SFU sfp_out
- omem_cen  out  1  OMEM chip enable, active low
- omem_wen  out  1  OMEM write enable, active low
- omem_addr  out  addr_bw  OMEM write address
- omem_wdata  out  psum_bw*col  combinational pass-through of sfp_in

Behaviour:
- Reset values: busy=0, done=0, pmem_cen=1, pmem_wen=1, pmem_addr=0, sfu_acc=0, sfu_bypass=0, omem_cen=1, omem_wen=1, omem_addr=0. Counters are cleared and the state is IDLE.
- Reset mid-operation aborts the pass immediately with no further memory accesses. The SFU accumulator self-clears on the next acc-low cycle.
- PMEM layout: psum(k,p) is at psum_base + k*num_pix + p, with k in 0..num_kij-1 and p in 0..num_pix-1. Address arithmetic is modulo 2^addr_bw.
- States: IDLE, READ, GAP, DRAIN.
  - IDLE: start=1 latches bases, sets p=0, k=0, goes to READ. start is ignored in every other state.
  - READ: pmem_cen=0 and pmem_addr=addr(k,p). If k=num_kij-1, go to GAP; else k++.
  - GAP: pmem_cen=1, k=0. If p=num_pix-1, go to DRAIN; else p++ and go to READ.
  - DRAIN: pmem_cen=1. Wait until the last pixel's OMEM write completes, then go to IDLE.
- sfu_acc is pmem read-issue (not pmem_cen) delayed one register. This puts acc high exactly in the cycles pmem_rdata is valid.
- Flush cycle: the cycle after GAP, where sfu_acc=0. The SFU latches ReLU(sum) into sfp_out at the end of this cycle and clears its accumulator. It may coincide with the next pixel's first READ cycle.
- Per-pixel period is num_kij+1 cycles with no other stall cycles. Any acc-low cycle inside a pixel's accumulation window corrupts the sum and is forbidden.
- OMEM write: omem_cen=0 and omem_wen=0 two cycles after each GAP cycle (GAP delayed two registers), with omem_addr = out_base + p delayed to match. This write cycle is the only cycle sfp_in holds that pixel's result: the SFU overwrites sfp_out on every acc-low cycle.
- Latency: for a start accepted at edge E0, READ begins in cycle 1. The last GAP is cycle G = num_pix*(num_kij+1), and done plus the last OMEM write occur in cycle G+2. busy is high in cycles 1..G+2.
- No backpressure: memories are single-cycle and always ready.

Test Plan:
- Params num_pix=2, num_kij=3, PMEM lane0 psums (k0..k2) p0={5,7,-2}, p1={-10,3,1}, bases 0 → OMEM[0] lane0=10, OMEM[1] lane0=0 (sum -6, ReLU); done in cycle 10; busy high in cycles 1..10.
- All 8 lanes carry distinct signed values, one lane's sum exactly 0 and one 0x7FFF-range value → per-lane independent ReLU; no cross-lane bleed.
- Probe sfu_acc across the full pass → acc-high runs of exactly num_kij cycles, each separated by exactly one acc-low cycle; pmem_wen and sfu_bypass never leave 1/0.
- psum_base=2^addr_bw-2 → PMEM addresses wrap to 0,1,…; correct OMEM results.
- start pulsed again while busy → ignored; assert reset in the middle of pixel 1 → all outputs return to reset values next cycle, no OMEM write; a new start runs a clean pass with correct results.
- Back-to-back starts: start again in the cycle after done → second pass gives identical OMEM contents and timing.
